serial_pattern_tx: RTL

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx_if.sv | 30 +++
 rtl/serial_pattern_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx_if.sv
// Parallel-load / serial-out handshake bundle for serial_pattern_tx.
// The transmitter sits on the slave side; whoever supplies words uses master.
interface serial_pattern_tx_if #(
   parameter int unsigned NUM_OF_BITS = 4
);
   logic                   Load;
   logic [NUM_OF_BITS-1:0] DataIn;
   logic                   Ready;
   logic                   SerOut;
   logic                   Busy;
   logic                   Done;

   modport master (
      output Load,
      output DataIn,
      input  Ready,
      input  SerOut,
      input  Busy,
      input  Done
   );

   modport slave (
      input  Load,
      input  DataIn,
      output Ready,
      output SerOut,
      output Busy,
      output Done
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// Frames a parallel word as start(0), data LSB first, optional even parity, stop(1).
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_pattern_tx #(
   parameter int unsigned NUM_OF_BITS = 4
) (
   input logic                Clk,
   input logic                Reset_n,
   serial_pattern_tx_if.slave bus
);

   localparam int unsigned CNT_W    = $clog2(NUM_OF_BITS) + 1;
   localparam int unsigned LAST_BIT = NUM_OF_BITS - 1;

   if (NUM_OF_BITS < 1 || NUM_OF_BITS > 16) begin : g_bad_width
      $error("serial_pattern_tx: NUM_OF_BITS must be within 1..16");
   end

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
`endif

   state_t                 state_q, state_n;
   logic [NUM_OF_BITS-1:0] shreg_q, shreg_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic                   ser_q, ser_n;
   logic                   done_q, done_n;
   logic                   ready_q, ready_n;
   logic                   busy_q, busy_n;
`ifdef SERIAL_TX_PARITY_EN
   logic                   parity_q, parity_n;
`endif

   // State and output registers; every output is a flop so Load/DataIn never reach SerOut combinationally
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         ser_q    <= 1'b1;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_n;
         shreg_q  <= shreg_n;
         cnt_q    <= cnt_n;
         ser_q    <= ser_n;
         done_q   <= done_n;
         ready_q  <= ready_n;
         busy_q   <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_n;
`endif
      end
   end

   // Next state plus the line level for the cycle being entered, so SerOut is aligned with state_q
   always_comb begin
      state_n  = state_q;
      shreg_n  = shreg_q;
      cnt_n    = cnt_q;
      ser_n    = 1'b1;
      done_n   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_n = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.Load) begin
               state_n  = START;
               shreg_n  = bus.DataIn;
               cnt_n    = '0;
               ser_n    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
               parity_n = ^bus.DataIn;
`endif
            end
         end
         START: begin
            state_n = DATA;
            cnt_n   = '0;
            ser_n   = shreg_q[0];
         end
         DATA: begin
            shreg_n = shreg_q >> 1;
            cnt_n   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LAST_BIT)) begin
`ifdef SERIAL_TX_PARITY_EN
               state_n = PARITY;
               ser_n   = parity_q;
`else
               state_n = STOP;
               done_n  = 1'b1;
`endif
            end else begin
               ser_n = shreg_n[0];
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            state_n = STOP;
            done_n  = 1'b1;
         end
`endif
         STOP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      ready_n = (state_n == IDLE);
      busy_n  = ~ready_n;
   end

   assign bus.SerOut = ser_q;
   assign bus.Done   = done_q;
   assign bus.Ready  = ready_q;
   assign bus.Busy   = busy_q;

endmodule
